// File: rtl/mainfsm.sv
// Moore main controller FSM of the multicycle ARM datapath.
// Next state and the control vector for that next state are registered together.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd15
    } state_t;

    state_t      r_state;
    logic [11:0] r_ctrl;
    logic        w_unused_funct;

    // Funct[4:1] select the ALU operation in the decoder, not here.
    assign w_unused_funct = ^Funct[4:1];

    function automatic state_t f_next(input state_t s, input logic [1:0] op, input logic [5:0] funct);
        case (s)
            S_FETCH:    f_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   f_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   f_next = S_MEMADR;
                    2'b10:   f_next = S_BRANCH;
                    default: f_next = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   f_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    f_next = S_MEMWB;
            S_EXECUTER: f_next = S_ALUWB;
            S_EXECUTEI: f_next = S_ALUWB;
            default:    f_next = S_FETCH;
        endcase
    endfunction

    // {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    function automatic logic [11:0] f_ctrl(input state_t s);
        case (s)
            S_FETCH:    f_ctrl = 12'b1_0_0_0_1_0_10_1_10_0;
            S_DECODE:   f_ctrl = 12'b0_0_0_0_0_0_10_1_10_0;
            S_EXECUTER: f_ctrl = 12'b0_0_0_0_0_0_00_0_00_1;
            S_EXECUTEI: f_ctrl = 12'b0_0_0_0_0_0_00_0_01_1;
            S_ALUWB:    f_ctrl = 12'b0_0_0_1_0_0_00_0_00_0;
            S_MEMADR:   f_ctrl = 12'b0_0_0_0_0_0_00_0_01_0;
            S_MEMRD:    f_ctrl = 12'b0_0_0_0_0_1_00_0_01_0;
            S_MEMWB:    f_ctrl = 12'b0_0_0_1_0_0_01_0_01_0;
            S_MEMWR:    f_ctrl = 12'b0_0_1_0_0_1_00_0_01_0;
            S_BRANCH:   f_ctrl = 12'b0_1_0_0_0_0_10_0_01_0;
            default:    f_ctrl = 12'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= f_ctrl(S_FETCH);
        end else begin
            r_state <= f_next(r_state, Op, Funct);
            r_ctrl  <= f_ctrl(f_next(r_state, Op, Funct));
        end
    end

    assign {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp} = r_ctrl;
    assign State = r_state;

endmodule
